// File: rtl/ula_arbitro.sv
// ula_arbitro: two-requester arbiter time-sharing an external 8-bit ALU (LIVRE -> EXEC -> RESP).
// Define ULA_ARBITRO_RR_EN for round-robin tie breaking; otherwise req0 has fixed priority.
module ula_arbitro (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic [2:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic [2:0] req1_op,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_dado,
  output logic       resp_zero,
  output logic [7:0] ula_entrada1,
  output logic [7:0] ula_entrada2,
  output logic [2:0] ula_sinal,
  input  logic [7:0] ula_saida
);
  typedef enum logic [1:0] {LIVRE, EXEC, RESP} state_t;
  state_t state_q, state_d;
  logic [7:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [2:0] op_q, op_d;
  logic id_q, id_d, zero_q, zero_d;
  logic grant1, accept;
`ifdef ULA_ARBITRO_RR_EN
  // last_q holds the requester granted most recently; reset to 1 so req0 wins the first tie
  logic last_q;
  assign grant1 = req1_valid & (~req0_valid | ~last_q);
  always_ff @(posedge clock or posedge reset)
    if (reset) last_q <= 1'b1;
    else if (accept) last_q <= grant1;
`else
  assign grant1 = req1_valid & ~req0_valid;
`endif
  assign accept       = (state_q == LIVRE) & (req0_valid | req1_valid);
  assign req0_ready   = accept & ~grant1;
  assign req1_ready   = accept & grant1;
  assign resp_valid   = state_q == RESP;
  assign resp_id      = id_q;
  assign resp_dado    = res_q;
  assign resp_zero    = zero_q;
  assign ula_entrada1 = a_q;
  assign ula_entrada2 = b_q;
  assign ula_sinal    = op_q;
  always_comb begin
    state_d = state_q;
    a_d     = accept ? (grant1 ? req1_a : req0_a) : a_q;
    b_d     = accept ? (grant1 ? req1_b : req0_b) : b_q;
    op_d    = accept ? (grant1 ? req1_op : req0_op) : op_q;
    id_d    = accept ? grant1 : id_q;
    res_d   = (state_q == EXEC) ? ula_saida : res_q;
    zero_d  = (state_q == EXEC) ? (ula_saida == 8'h00) : zero_q;
    case (state_q)
      LIVRE:   state_d = accept ? EXEC : LIVRE;
      EXEC:    state_d = RESP;
      RESP:    state_d = resp_ready ? LIVRE : RESP;
      default: state_d = LIVRE;
    endcase
  end
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= LIVRE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      id_q    <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      id_q    <= id_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
    end
endmodule

// File: tb/tb_ula_arbitro.sv
// tb_ula_arbitro: directed vectors against ula_arbitro with a behavioural ALU on the shared port.
module tb_ula_arbitro;
  logic clock = 1'b0, reset = 1'b1;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [7:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0] req0_op = 0, req1_op = 0;
  logic resp_valid, resp_ready = 0, resp_id, resp_zero;
  logic [7:0] resp_dado, ula_entrada1, ula_entrada2, ula_saida;
  logic [2:0] ula_sinal;
  int checks = 0, failures = 0;

  ula_arbitro dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id), .resp_dado(resp_dado),
    .resp_zero(resp_zero), .ula_entrada1(ula_entrada1), .ula_entrada2(ula_entrada2),
    .ula_sinal(ula_sinal), .ula_saida(ula_saida)
  );

  always #5 clock = ~clock;

  always_comb
    case (ula_sinal)
      3'd0:    ula_saida = ula_entrada1 & ula_entrada2;
      3'd1:    ula_saida = ula_entrada1 | ula_entrada2;
      3'd2:    ula_saida = ula_entrada1 + ula_entrada2;
      3'd3:    ula_saida = ula_entrada1 - ula_entrada2;
      3'd4:    ula_saida = {7'd0, $signed(ula_entrada1) < $signed(ula_entrada2)};
      default: ula_saida = 8'h00;
    endcase

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_rv"}, resp_valid, 0);
    check({tag, "_rdy"}, {req0_ready, req1_ready}, 0);
    check({tag, "_e1"}, ula_entrada1, 0);
    check({tag, "_e2"}, ula_entrada2, 0);
    check({tag, "_sinal"}, ula_sinal, 0);
    check({tag, "_dado"}, resp_dado, 0);
    check({tag, "_zero"}, resp_zero, 0);
    check({tag, "_id"}, resp_id, 0);
  endtask

  // Present one request at a negedge, follow it through EXEC and RESP, then acknowledge.
  task automatic do_op(input string tag, input logic n, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input logic [7:0] exp_dado, input logic exp_zero);
    @(negedge clock);
    if (n) begin req1_valid = 1; req1_a = a; req1_b = b; req1_op = op; end
    else   begin req0_valid = 1; req0_a = a; req0_b = b; req0_op = op; end
    #1 check({tag, "_ready"}, {req1_ready, req0_ready}, n ? 2'b10 : 2'b01);
    @(negedge clock);
    req0_valid = 0; req1_valid = 0;
    #1 check({tag, "_exec_rv"}, resp_valid, 0);
    check({tag, "_exec_ops"}, {ula_entrada1, ula_entrada2}, {a, b});
    check({tag, "_exec_sinal"}, ula_sinal, op);
    @(negedge clock);
    #1 check({tag, "_rv"}, resp_valid, 1);
    check({tag, "_dado"}, resp_dado, exp_dado);
    check({tag, "_zero"}, resp_zero, exp_zero);
    check({tag, "_id"}, resp_id, n);
    resp_ready = 1;
    @(negedge clock);
    resp_ready = 0;
    #1 check({tag, "_done"}, resp_valid, 0);
  endtask

  initial begin
    logic [3:0] ids, exp_ids;
    int got;
    #1 check_idle("rst_during");
    @(negedge clock); reset = 0;
    #1 check_idle("rst_after");

    do_op("add", 0, 8'd5, 8'd3, 3'b010, 8'h08, 0);
    do_op("sub0", 1, 8'h2A, 8'h2A, 3'b011, 8'h00, 1);
    do_op("slt", 1, 8'd3, 8'd7, 3'b100, 8'h01, 0);
    do_op("or", 0, 8'hA0, 8'h05, 3'b001, 8'hA5, 0);
    do_op("op7", 0, 8'hFF, 8'hFF, 3'b111, 8'h00, 1);

    // Response stall: everything frozen and no grants while RESP waits
    @(negedge clock);
    req0_valid = 1; req0_a = 8'h10; req0_b = 8'h22; req0_op = 3'b010;
    @(negedge clock);
    req1_valid = 1; req1_a = 8'h01; req1_b = 8'h01; req1_op = 3'b000;
    @(negedge clock);
    for (int i = 0; i < 5; i++) begin
      #1 check("stall_rv", resp_valid, 1);
      check("stall_dado", resp_dado, 8'h32);
      check("stall_ula", {ula_entrada1, ula_entrada2, 5'd0, ula_sinal}, {8'h10, 8'h22, 8'd2});
      check("stall_rdy", {req0_ready, req1_ready}, 0);
      @(negedge clock);
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 1;
    @(negedge clock);
    resp_ready = 0;
    #1 check("stall_done", resp_valid, 0);

    // Reset while in EXEC aborts the operation
    @(negedge clock);
    req0_valid = 1; req0_a = 8'hFF; req0_b = 8'h01; req0_op = 3'b010;
    @(negedge clock);
    req0_valid = 0; reset = 1;
    #1 check_idle("abort");
    @(negedge clock); reset = 0;
    @(negedge clock);
    #1 check("abort_norv", resp_valid, 0);
    do_op("post_rst", 0, 8'd1, 8'd1, 3'b000, 8'h01, 0);

    // Tie: both valid continuously, consumer always ready
    @(negedge clock); reset = 1;
    @(negedge clock); reset = 0;
    req0_valid = 1; req0_a = 8'd1; req0_b = 8'd1; req0_op = 3'b010;
    req1_valid = 1; req1_a = 8'd2; req1_b = 8'd2; req1_op = 3'b010;
    resp_ready = 1;
    got = 0; ids = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clock);
      #1 if (resp_valid) begin ids[got] = resp_id; got++; end
    end
    req0_valid = 0; req1_valid = 0; resp_ready = 0;
    check("tie_count", got, 4);
`ifdef ULA_ARBITRO_RR_EN
    exp_ids = 4'b1010;
`else
    exp_ids = 4'b0000;
`endif
    check("tie_ids", ids, exp_ids);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
